// File: rtl/collision_scan_scheduler_if.sv
// Bus between the collision scan scheduler, the game FSM and the layer memories.
// The slave modport is the scheduler side; master is the game FSM plus memory side.
interface collision_scan_scheduler_if #(
  parameter int NUM_AST = 16
);
  logic               start;
  logic               abort;
  logic [NUM_AST-1:0] ast_enable;
  logic [7:0]         pix_x;
  logic [6:0]         pix_y;
  logic [14:0]        pix_addr;
  logic               pix_rd;
  logic               ship_bit;
  logic [NUM_AST-1:0] ast_bits;
  logic               busy;
  logic               done;
  logic [NUM_AST-1:0] hit_mask;
  logic [4:0]         hit_count;
  logic               ship_hit;
  logic [7:0]         first_x;
  logic [6:0]         first_y;
  logic               first_valid;

  modport master (
    output start, abort, ast_enable, ship_bit, ast_bits,
    input  pix_x, pix_y, pix_addr, pix_rd, busy, done,
           hit_mask, hit_count, ship_hit, first_x, first_y, first_valid
  );

  modport slave (
    input  start, abort, ast_enable, ship_bit, ast_bits,
    output pix_x, pix_y, pix_addr, pix_rd, busy, done,
           hit_mask, hit_count, ship_hit, first_x, first_y, first_valid
  );
endinterface

// File: rtl/collision_scan_scheduler.sv
// Raster-scans the frame buffer once per start, ANDing the ship layer with each enabled
// asteroid layer; accumulates hit mask, hit count and first collision coordinate.
module collision_scan_scheduler #(
  parameter int NUM_AST = 16,
  parameter int H_RES   = 160,
  parameter int V_RES   = 120
) (
  input logic                      clock,
  input logic                      resetn,
  collision_scan_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_x, r_x_q, r_fx;
  logic [6:0]         r_y, r_y_q, r_fy;
  logic               r_rd_q, r_first_fnd;
  logic [NUM_AST-1:0] r_en, r_acc;

  logic [NUM_AST-1:0] r_hit_mask;
  logic [4:0]         r_hit_count;
  logic               r_ship_hit, r_first_valid;
  logic [7:0]         r_first_x;
  logic [6:0]         r_first_y;

  logic               w_last_pix, w_accept, w_publish, w_pix_rd;
  logic [NUM_AST-1:0] w_hits, w_acc_nxt;
  logic               w_first_fnd_nxt;
  logic [7:0]         w_fx_nxt;
  logic [6:0]         w_fy_nxt;
  logic [4:0]         w_count;

  assign w_last_pix = (r_x == 8'(H_RES - 1)) && (r_y == 7'(V_RES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_pix_rd    = 1'b0;
    w_accept    = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_pix_rd = 1'b1;
        if (bus.abort)       w_state_nxt = IDLE;
        else if (w_last_pix) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
          w_publish   = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data belongs to the address issued one cycle earlier, hence the delayed x/y.
  always_comb begin
    w_hits          = r_rd_q ? ({NUM_AST{bus.ship_bit}} & bus.ast_bits & r_en) : '0;
    w_acc_nxt       = r_acc | w_hits;
    w_first_fnd_nxt = r_first_fnd | (|w_hits);
    w_fx_nxt        = r_fx;
    w_fy_nxt        = r_fy;
    if (!r_first_fnd && (|w_hits)) begin
      w_fx_nxt = r_x_q;
      w_fy_nxt = r_y_q;
    end
    w_count = '0;
    for (int unsigned i = 0; i < NUM_AST; i++) begin
      w_count = w_count + 5'(w_acc_nxt[i]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x         <= '0;
      r_y         <= '0;
      r_x_q       <= '0;
      r_y_q       <= '0;
      r_rd_q      <= 1'b0;
      r_en        <= '0;
      r_acc       <= '0;
      r_first_fnd <= 1'b0;
      r_fx        <= '0;
      r_fy        <= '0;
    end else begin
      r_rd_q <= w_pix_rd;
      r_x_q  <= r_x;
      r_y_q  <= r_y;
      if (w_accept) begin
        r_x         <= '0;
        r_y         <= '0;
        r_en        <= bus.ast_enable;
        r_acc       <= '0;
        r_first_fnd <= 1'b0;
        r_fx        <= '0;
        r_fy        <= '0;
      end else begin
        r_acc       <= w_acc_nxt;
        r_first_fnd <= w_first_fnd_nxt;
        r_fx        <= w_fx_nxt;
        r_fy        <= w_fy_nxt;
        if (r_state == SCAN && !w_last_pix) begin
          if (r_x == 8'(H_RES - 1)) begin
            r_x <= '0;
            r_y <= r_y + 7'd1;
          end else begin
            r_x <= r_x + 8'd1;
          end
        end
      end
    end
  end

  // Results are loaded from the merged DRAIN sample so they are visible with done.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hit_mask    <= '0;
      r_hit_count   <= '0;
      r_ship_hit    <= 1'b0;
      r_first_x     <= '0;
      r_first_y     <= '0;
      r_first_valid <= 1'b0;
    end else if (w_publish) begin
      r_hit_mask    <= w_acc_nxt;
      r_hit_count   <= w_count;
      r_ship_hit    <= |w_acc_nxt;
      r_first_x     <= w_fx_nxt;
      r_first_y     <= w_fy_nxt;
      r_first_valid <= w_first_fnd_nxt;
    end
  end

  assign bus.pix_x       = r_x;
  assign bus.pix_y       = r_y;
  assign bus.pix_addr    = 15'(r_y) * 15'(H_RES) + 15'(r_x);
  assign bus.pix_rd      = w_pix_rd;
  assign bus.busy        = (r_state == SCAN) || (r_state == DRAIN);
  assign bus.done        = (r_state == DONE);
  assign bus.hit_mask    = r_hit_mask;
  assign bus.hit_count   = r_hit_count;
  assign bus.ship_hit    = r_ship_hit;
  assign bus.first_x     = r_first_x;
  assign bus.first_y     = r_first_y;
  assign bus.first_valid = r_first_valid;

endmodule

// File: doc/collision_scan_scheduler.md
Name: collision_scan_scheduler

Overview:
Sequences the per-pixel collision check between the ship layer and up to NUM_AST asteroid layers. Each check is one raster scan of the 160x120 frame buffer, one pixel per clock, through a shared read port with 1-cycle latency. On start it walks every pixel address and ANDs the ship bit with each enabled asteroid bit. It accumulates a per-asteroid hit mask, a hit count and the first collision coordinate, then pulses done. It sits between the game FSM (start/abort) and the layer memories (address out, bits in).

Parameters:
NUM_AST, 16, number of asteroid layers checked in parallel (1..16)
H_RES, 160, pixels per row; x counter wraps at H_RES-1
V_RES, 120, rows per frame; scan ends after row V_RES-1

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a scan; honoured only in IDLE
abort  in  1  synchronous cancel; honoured in SCAN/DRAIN
ast_enable  in  NUM_AST  per-asteroid enable, sampled on the accepted start cycle
pix_x  out  8  current read column
pix_y  out  7  current read row
pix_addr  out  15  pix_y*H_RES + pix_x
pix_rd  out  1  read strobe; address valid this cycle
ship_bit  in  1  ship layer bit for address issued previous cycle
ast_bits  in  NUM_AST  asteroid layer bits for address issued previous cycle
busy  out  1  high in SCAN and DRAIN
done  out  1  one-cycle pulse when results update
hit_mask  out  NUM_AST  bit i = asteroid i collided with ship in last completed scan
hit_count  out  5  popcount of hit_mask
ship_hit  out  1  OR of hit_mask
first_x  out  8  column of first colliding pixel in raster order
first_y  out  7  row of first colliding pixel
first_valid  out  1  first_x/first_y meaningful

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0; accumulators, enable latch, pipeline flag cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: pix_rd=0. start=1 at cycle T -> latch ast_enable, clear accumulators, go SCAN; T+1 presents (0,0), pix_rd=1.
- SCAN: pix_rd=1 every cycle; pix_x increments; at pix_x=H_RES-1 -> pix_x=0, pix_y+1. Issuing (H_RES-1,V_RES-1) goes DRAIN next cycle. Last address issued at T+19200.
- DRAIN (T+19201): pix_rd=0, pix_x/pix_y hold; last pixel's data sampled.
- DONE (T+19202): done=1; hit_mask/hit_count/ship_hit/first_* load from accumulators; busy=0; next state IDLE.
- Sampling: rd_q = pix_rd delayed 1 cycle, with matching delayed x/y. When rd_q=1, acc[i] |= ship_bit & ast_bits[i] & en_q[i].
- First hit: first rd_q cycle with any enabled collision records the delayed x/y; later hits do not overwrite.
- ship_bit/ast_bits are ignored when rd_q=0.
- Results hold from one DONE to the next; they are not cleared at start.
- start while busy or in DONE: ignored; no queueing.
- abort in SCAN/DRAIN: next state IDLE; pix_rd=0 next cycle; no done pulse; result outputs unchanged.
- abort in IDLE/DONE: no effect. abort and start in the same IDLE cycle: start wins.
- ast_enable changes mid-scan have no effect; the latched copy is used.
- resetn low mid-scan: immediate IDLE, all outputs 0.
- Arithmetic: pix_addr = y*160+x computed combinationally from the counters; max 19199; no overflow in 15 bits. hit_count max 16, 5 bits.

Test Plan:
- No collisions, ast_enable=FFFF: start at T -> pix_rd high T+1..T+19200, done at T+19202, hit_mask=0, ship_hit=0, first_valid=0.
- Ship and asteroid 3 both set at (0,0) -> hit_mask=0008, hit_count=1, first_x=0, first_y=0, first_valid=1.
- Collision only at (159,119), asteroid 15 (pix_addr 19199, sampled in DRAIN) -> hit_mask=8000, first=(159,119).
- Asteroid 1 at (10,5), asteroid 4 at (3,2), asteroid 7 at (0,0) with ast_enable bit7=0 -> hit_mask=0012, hit_count=2, first=(3,2).
- start pulsed at T+500 during scan -> ignored, done still at T+19202; second scan's abort at cycle 1000 -> no done, outputs keep prior values, pix_rd low next cycle.
- resetn low at T+7000 -> all outputs 0 immediately; a new start after release scans from (0,0).
